// File: rtl/riscv_cpu_pkg.sv
// Shared fetch-side types and constants for the riscv_cpu core.
package riscv_cpu_pkg;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    FLUSH
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer of {addr, instr} pairs; flush empties it on the same edge.
module fetch_fifo
  import riscv_cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic [31:0]   push_addr_i,
  input  logic [31:0]   push_instr_i,
  input  logic          pop_i,
  output logic [31:0]   head_addr_o,
  output logic [31:0]   head_instr_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  assign empty_o      = (r_count == '0);
  assign full_o       = (r_count == CW'(DEPTH));
  assign count_o      = r_count;
  assign w_pop        = pop_i & ~empty_o & ~flush_i;
  // A full buffer can still accept a word in the cycle its head leaves.
  assign w_push       = push_i & ~flush_i & (~full_o | w_pop);
  assign head_addr_o  = r_mem[r_rd_ptr].addr;
  assign head_instr_o = r_mem[r_rd_ptr].instr;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= '{addr: push_addr_i, instr: push_instr_i};
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: single-outstanding memory requester feeding a prefetch buffer.
//   state | meaning
//   BOOT  | first cycle after reset, no request
//   RUN   | normal fetching, responses go to the buffer
//   FLUSH | redirected; waiting for a stale request/response to drain
module fetch_stage
  import riscv_cpu_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR  = DEFAULT_BOOT_ADDR,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        instr_req_o,
  output logic [31:0] instr_addr_o,
  input  logic        instr_gnt_i,
  input  logic        instr_rvalid_i,
  input  logic [31:0] instr_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_addr_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  input  logic        instr_ready_i
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e  r_state;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_target;
  logic [31:0]   r_out_addr;
  logic [31:0]   r_pc_last;
  logic          r_outstanding;
  logic          r_pending;

  logic [CW-1:0] w_count;
  logic [CW:0]   w_occ;
  logic          w_full;
  logic          w_empty;
  logic [31:0]   w_head_addr;
  logic [31:0]   w_head_instr;
  logic [31:0]   w_redirect_pc;
  logic          w_req;
  logic          w_gnt;
  logic          w_rsp;
  logic          w_pop;
  logic          w_push;
  logic          w_room;
  logic          w_out_next;
  logic          w_pend_next;

  assign w_redirect_pc = word_align(redirect_addr_i);
  assign w_pop         = ~w_empty & instr_ready_i;
  // A response arriving now is still counted as in flight until it lands in the buffer.
  assign w_occ         = {1'b0, w_count} + (CW+1)'(r_outstanding) - (CW+1)'(w_pop);
  assign w_room        = (w_occ < (CW+1)'(FIFO_DEPTH));
  assign w_req         = r_pending |
                         ((r_state == RUN) & (~r_outstanding | instr_rvalid_i) & w_room);
  assign w_gnt         = w_req & instr_gnt_i;
  assign w_rsp         = r_outstanding & instr_rvalid_i;
  assign w_push        = w_rsp & (r_state == RUN) & ~redirect_i & (~w_full | w_pop);
  assign w_out_next    = w_gnt | (r_outstanding & ~instr_rvalid_i);
  assign w_pend_next   = w_req & ~instr_gnt_i;

  assign instr_req_o   = w_req;
  assign instr_addr_o  = r_fetch_pc;
  assign instr_valid_o = ~w_empty;
  assign instr_o       = w_empty ? NOP_INSTR : w_head_instr;
  assign pc_o          = w_empty ? r_pc_last : w_head_addr;

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .flush_i      (redirect_i),
    .push_i       (w_push),
    .push_addr_i  (r_out_addr),
    .push_instr_i (instr_rdata_i),
    .pop_i        (w_pop),
    .head_addr_o  (w_head_addr),
    .head_instr_o (w_head_instr),
    .full_o       (w_full),
    .empty_o      (w_empty),
    .count_o      (w_count)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state       <= BOOT;
      r_fetch_pc    <= BOOT_ADDR;
      r_target      <= BOOT_ADDR;
      r_out_addr    <= '0;
      r_pc_last     <= '0;
      r_outstanding <= 1'b0;
      r_pending     <= 1'b0;
    end else begin
      r_outstanding <= w_out_next;
      r_pending     <= w_pend_next;
      if (w_gnt)    r_out_addr <= r_fetch_pc;
      if (!w_empty) r_pc_last  <= w_head_addr;
      case (r_state)
        BOOT: begin
          r_state <= RUN;
          if (redirect_i) r_fetch_pc <= w_redirect_pc;
        end
        RUN: begin
          if (redirect_i) begin
            // Anything still in flight must drain before fetching from the target.
            if (w_out_next | w_pend_next) begin
              r_state  <= FLUSH;
              r_target <= w_redirect_pc;
            end else begin
              r_fetch_pc <= w_redirect_pc;
            end
          end else if (w_gnt) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
          end
        end
        FLUSH: begin
          if (!(w_out_next | w_pend_next)) begin
            r_state    <= RUN;
            r_fetch_pc <= redirect_i ? w_redirect_pc : r_target;
          end else if (redirect_i) begin
            r_target <= w_redirect_pc;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; memory returns ~addr as the instruction word.
module tb_fetch_stage;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i = 1'b1;
  logic        instr_rvalid_i = 1'b0;
  logic [31:0] instr_rdata_i = 32'h0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_addr_i = 32'h0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic        instr_ready_i = 1'b1;

  int n_checks = 0;
  int n_errors = 0;
  int rsp_lat  = 1;

  logic        s_g = 1'b0;
  logic [31:0] s_a = 32'h0;
  logic        m_pend = 1'b0;
  int          m_cnt = 0;
  logic [31:0] m_addr = 32'h0;

  fetch_stage #(.BOOT_ADDR(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk_i           (clk_i),
    .rst_i           (rst_i),
    .instr_req_o     (instr_req_o),
    .instr_addr_o    (instr_addr_o),
    .instr_gnt_i     (instr_gnt_i),
    .instr_rvalid_i  (instr_rvalid_i),
    .instr_rdata_i   (instr_rdata_i),
    .redirect_i      (redirect_i),
    .redirect_addr_i (redirect_addr_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .instr_ready_i   (instr_ready_i)
  );

  always #5 clk_i = ~clk_i;

  // Memory: grant seen mid-cycle, response rsp_lat cycles after the granting edge.
  always @(negedge clk_i) begin
    s_g = instr_req_o & instr_gnt_i;
    s_a = instr_addr_o;
  end

  always @(posedge clk_i) begin
    #1;
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = 32'hDEAD_BEEF;
    if (s_g) begin
      m_pend = 1'b1;
      m_cnt  = rsp_lat;
      m_addr = s_a;
    end
    if (m_pend) begin
      m_cnt = m_cnt - 1;
      if (m_cnt == 0) begin
        instr_rvalid_i = 1'b1;
        instr_rdata_i  = ~m_addr;
        m_pend         = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #2;
  endtask

  task automatic do_reset(input logic rdy, input int lat);
    rst_i         = 1'b1;
    redirect_i    = 1'b0;
    instr_gnt_i   = 1'b1;
    instr_ready_i = rdy;
    rsp_lat       = lat;
    tick();
    tick();
    rst_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    int n = 0;
    while (!instr_valid_o && n < max_cycles) begin
      tick();
      n++;
    end
    check(tag, 32'(instr_valid_o), 32'h1);
  endtask

  initial begin
    // reset values
    tick();
    tick();
    check("rst_req",   32'(instr_req_o),   32'h0);
    check("rst_addr",  instr_addr_o,       32'h0000_0000);
    check("rst_valid", 32'(instr_valid_o), 32'h0);
    check("rst_instr", instr_o,            32'h0000_0013);
    check("rst_pc",    pc_o,               32'h0000_0000);

    // streaming, zero-wait memory
    do_reset(1'b1, 1);
    check("boot_noreq", 32'(instr_req_o), 32'h0);
    tick();
    check("run_req",  32'(instr_req_o), 32'h1);
    check("run_addr", instr_addr_o,     32'h0000_0000);
    tick();
    check("no_bypass", 32'(instr_valid_o), 32'h0);
    tick();
    check("s0_valid", 32'(instr_valid_o), 32'h1);
    check("s0_pc",    pc_o,    32'h0000_0000);
    check("s0_instr", instr_o, 32'hFFFF_FFFF);
    tick();
    check("s1_valid", 32'(instr_valid_o), 32'h1);
    check("s1_pc",    pc_o,    32'h0000_0004);
    check("s1_instr", instr_o, 32'hFFFF_FFFB);
    tick();
    check("s2_valid", 32'(instr_valid_o), 32'h1);
    check("s2_pc",    pc_o,    32'h0000_0008);
    check("s2_instr", instr_o, 32'hFFFF_FFF7);

    // back-pressure fills the buffer and stops requests
    do_reset(1'b0, 1);
    repeat (5) tick();
    check("bp_req",   32'(instr_req_o),   32'h0);
    check("bp_valid", 32'(instr_valid_o), 32'h1);
    check("bp_pc",    pc_o, 32'h0000_0000);
    instr_ready_i = 1'b1;
    check("bp_instr0", instr_o, 32'hFFFF_FFFF);
    tick();
    check("bp_pc1",    pc_o,    32'h0000_0004);
    check("bp_instr1", instr_o, 32'hFFFF_FFFB);
    tick();
    check("bp_pc2",    pc_o,    32'h0000_0008);

    // redirect latency, alignment and address wrap
    do_reset(1'b0, 1);
    repeat (5) tick();
    redirect_i      = 1'b1;
    redirect_addr_i = 32'hFFFF_FFFF;
    tick();
    redirect_i = 1'b0;
    check("lat_flush_valid", 32'(instr_valid_o), 32'h0);
    check("lat_flush_instr", instr_o, 32'h0000_0013);
    check("lat_hold_pc",     pc_o,    32'h0000_0000);
    check("lat_req",         32'(instr_req_o), 32'h1);
    check("lat_addr",        instr_addr_o, 32'hFFFF_FFFC);
    instr_ready_i = 1'b1;
    tick();
    check("wrap_valid", 32'(instr_valid_o), 32'h0);
    check("wrap_req",   32'(instr_req_o),   32'h1);
    check("wrap_addr",  instr_addr_o, 32'h0000_0000);
    tick();
    check("lat_valid3", 32'(instr_valid_o), 32'h1);
    check("lat_pc",     pc_o,    32'hFFFF_FFFC);
    check("lat_instr",  instr_o, 32'h0000_0003);
    tick();
    check("wrap_pc",    pc_o,    32'h0000_0000);
    check("wrap_instr", instr_o, 32'hFFFF_FFFF);

    // redirect with a granted response still outstanding
    do_reset(1'b1, 3);
    tick();
    tick();
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h0000_0103;
    check("out_req_hold", 32'(instr_req_o), 32'h0);
    tick();
    redirect_i = 1'b0;
    check("out_flush_req", 32'(instr_req_o), 32'h0);
    tick();
    check("out_stale_req", 32'(instr_req_o), 32'h0);
    tick();
    check("out_stale_drop", 32'(instr_valid_o), 32'h0);
    check("out_new_req",    32'(instr_req_o),   32'h1);
    check("out_new_addr",   instr_addr_o, 32'h0000_0100);
    wait_valid("out_wait", 10);
    check("out_pc",    pc_o,    32'h0000_0100);
    check("out_instr", instr_o, 32'hFFFF_FEFF);

    // redirect while the request is still waiting for grant
    do_reset(1'b1, 1);
    instr_gnt_i = 1'b0;
    tick();
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h0000_0300;
    check("pend_req1",  32'(instr_req_o), 32'h1);
    check("pend_addr1", instr_addr_o, 32'h0000_0000);
    tick();
    redirect_i = 1'b0;
    check("pend_req2",  32'(instr_req_o), 32'h1);
    check("pend_addr2", instr_addr_o, 32'h0000_0000);
    tick();
    check("pend_addr3", instr_addr_o, 32'h0000_0000);
    tick();
    instr_gnt_i = 1'b1;
    check("pend_req4",  32'(instr_req_o), 32'h1);
    check("pend_addr4", instr_addr_o, 32'h0000_0000);
    tick();
    check("pend_drain_req",   32'(instr_req_o),   32'h0);
    check("pend_drain_valid", 32'(instr_valid_o), 32'h0);
    tick();
    check("pend_tgt_req",  32'(instr_req_o), 32'h1);
    check("pend_tgt_addr", instr_addr_o, 32'h0000_0300);
    wait_valid("pend_wait", 10);
    check("pend_pc",    pc_o,    32'h0000_0300);
    check("pend_instr", instr_o, 32'hFFFF_FCFF);

    // reset in the middle of a transaction with buffered data
    do_reset(1'b0, 3);
    repeat (5) tick();
    check("mid_valid", 32'(instr_valid_o), 32'h1);
    check("mid_pc",    pc_o, 32'h0000_0000);
    rst_i = 1'b1;
    #1;
    check("mid_rst_valid", 32'(instr_valid_o), 32'h0);
    check("mid_rst_instr", instr_o, 32'h0000_0013);
    check("mid_rst_req",   32'(instr_req_o), 32'h0);
    check("mid_rst_pc",    pc_o, 32'h0000_0000);
    tick();
    rst_i = 1'b0;
    tick();
    check("late_req",   32'(instr_req_o), 32'h1);
    check("late_addr",  instr_addr_o, 32'h0000_0000);
    tick();
    check("late_drop", 32'(instr_valid_o), 32'h0);
    wait_valid("late_wait", 10);
    check("late_pc",    pc_o,    32'h0000_0000);
    check("late_instr", instr_o, 32'hFFFF_FFFF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
